systolic_output_deskew: RTL and testbench
=========================================

# systolic_output_deskew

Drain-side companion to the systolic matrix multiply array. It captures the diagonally skewed partial-sum results leaving the array's bottom row and delays each column so that one output row arrives as a single aligned vector. Aligned rows are buffered in a small FIFO and presented downstream with a valid/ready handshake. It sits between the array's PsumOut bottom edge and the activation/writeback stage.

## Interface
- WIDTH, 8, operand width; result width PW = 2*WIDTH+1 per column.
- LENGTH, 256, number of array columns.
- DEPTH, 4, FIFO depth in aligned rows; power of two, >= 2.
- CLK  in  1  clock; all logic is on the rising edge.
- SYNC_RST  in  1  synchronous, active-high reset.
- EN  in  1  array advance enable; when low, the deskew pipeline holds.
- IN_VALID  in  1  marks column 0 result of a row; column c of that row arrives c enabled cycles later.
- PSUM_IN  in  PW*LENGTH  bottom-row results; column 0 in the MSB slice, column c at [PW*LENGTH-c*PW-1 : PW*LENGTH-(c+1)*PW].
- OUT_VALID  out  1  FIFO head valid.
- OUT_READY  in  1  downstream accepts the head.
- OUT_DATA  out  PW*LENGTH  aligned row, same column packing as PSUM_IN.
- COUNT  out  clog2(DEPTH)+1  rows held in the FIFO.
- OVERFLOW  out  1  sticky; set when an aligned row is dropped.

## Operation
- Deskew: column c passes through LENGTH-1-c registers. Column LENGTH-1 has zero delay and feeds the write path combinationally.
- Valid pipeline: IN_VALID enters a LENGTH-1 stage shift register. The last stage is the aligned write strobe WR.
- EN gating: the data and valid shift registers advance only when EN=1. WR is qualified with EN, so a frozen pipeline never writes.
- FIFO: first-word-fall-through; OUT_DATA = mem[rd_ptr].
  - Write occurs on WR & (not full, or a read in the same cycle).
  - Read occurs on OUT_VALID & OUT_READY.
- Full with WR and no read: the row is dropped, OVERFLOW is set, and the pointers and COUNT are unchanged.
- Full with WR and a read in the same cycle: both are performed and COUNT is unchanged.
- Empty with WR and OUT_READY=1: the row is written. It is not bypassed to the output; OUT_VALID rises the next cycle.
- Pointers wrap modulo DEPTH. COUNT equals writes minus reads and never exceeds DEPTH.
- The read side ignores EN. The downstream stage can drain while the array is stalled.
- The data path has no arithmetic. Values pass bit-exact, with no sign extension or truncation.
- OVERFLOW clears only on SYNC_RST.

## Timing
- Reset, synchronous and taking effect on the edge where SYNC_RST=1:
  - Outputs: OUT_VALID=0, COUNT=0, OVERFLOW=0, OUT_DATA=0.
  - Internal: the valid shift register and the pointers clear, and the deskew data registers clear to 0.
- SYNC_RST has priority over writes and reads in the same cycle. A row in flight in the deskew pipeline is discarded.
- Latency: IN_VALID at cycle t (EN held high) gives WR in cycle t+LENGTH-1, and OUT_VALID=1 with the row in cycle t+LENGTH.
  - LENGTH=1 degenerates to zero delay stages: WR = IN_VALID & EN, and latency is 1.
- Each cycle with EN=0 inside the window adds one cycle of latency.
- Throughput: one row per enabled cycle. Back-to-back IN_VALID rows emerge back-to-back when OUT_READY stays high.
- OUT_VALID and OUT_DATA are stable while OUT_VALID=1 and OUT_READY=0.

## Test plan
Bench configuration: LENGTH=4, WIDTH=8, PW=17, DEPTH=4.
- Single row: IN_VALID at t=0, columns 0..3 driven with 17'h00001..17'h00004 at t=0..3, OUT_READY=1 -> OUT_VALID high in cycle 4 only, OUT_DATA={1,2,3,4}, COUNT returns to 0.
- Streaming: 8 consecutive skewed rows r=0..7 (column c value = 16*r+c), OUT_READY=1 -> 8 consecutive OUT_VALID cycles starting at cycle 4, rows in order, OVERFLOW=0.
- Backpressure/overflow: OUT_READY=0, 5 rows -> COUNT=4 and OVERFLOW=1 after the 5th WR. Raising OUT_READY then yields rows 0..3; row 4 is absent.
- Full + simultaneous read: FIFO at COUNT=4, WR in the same cycle as a handshake -> COUNT stays 4, OVERFLOW stays 0, new row exits last.
- EN stall: EN=0 for 2 cycles at t=2 of a skewed row -> OUT_VALID at cycle 6, data still {1,2,3,4}; no spurious write occurs while EN=0.
- Reset mid-operation: SYNC_RST at t=2 of an in-flight row, with COUNT=2 -> next cycle OUT_VALID=0, COUNT=0, OVERFLOW=0, and no output ever appears for the in-flight row.

Source files
------------

// File: rtl/systolic_output_deskew.sv
// Re-aligns the skewed bottom-row psums into whole rows and queues them in a FWFT FIFO; IN_VALID-to-OUT_VALID latency LENGTH enabled cycles.
// Read side is valid/ready and ignores EN; a row aligned while the FIFO is full and not being read is dropped and flagged in OVERFLOW.
module systolic_output_deskew #(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 256,
    parameter int DEPTH  = 4,
    localparam int PW = 2*WIDTH + 1,
    localparam int DW = PW*LENGTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          SYNC_RST,
    input  logic          EN,
    input  logic          IN_VALID,
    input  logic [DW-1:0] PSUM_IN,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [DW-1:0] OUT_DATA,
    output logic [CW-1:0] COUNT,
    output logic          OVERFLOW
);

    logic [DW-1:0] aligned;
    logic          wr;

    // Column c arrives c cycles after column 0, so it is held LENGTH-1-c cycles to line up.
    for (genvar c = 0; c < LENGTH; c++) begin : g_col
        localparam int D  = LENGTH - 1 - c;
        localparam int HI = DW - c*PW - 1;
        if (D == 0) begin : g_pass
            assign aligned[HI -: PW] = PSUM_IN[HI -: PW];
        end else begin : g_dly
            logic [PW-1:0] sr [D];
            always_ff @(posedge CLK) begin
                if (SYNC_RST) begin
                    for (int k = 0; k < D; k++) sr[k] <= '0;
                end else if (EN) begin
                    sr[0] <= PSUM_IN[HI -: PW];
                    for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
                end
            end
            assign aligned[HI -: PW] = sr[D-1];
        end
    end

    if (LENGTH == 1) begin : g_vld_none
        assign wr = IN_VALID & EN;
    end else begin : g_vld
        logic [LENGTH-2:0] vld_sr;
        always_ff @(posedge CLK) begin
            if (SYNC_RST) begin
                vld_sr <= '0;
            end else if (EN) begin
                vld_sr[0] <= IN_VALID;
                for (int k = 1; k < LENGTH-1; k++) vld_sr[k] <= vld_sr[k-1];
            end
        end
        assign wr = vld_sr[LENGTH-2] & EN;
    end

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          rd;
    logic          wr_acc;

    assign OUT_VALID = (COUNT != '0);
    assign OUT_DATA  = mem[rd_ptr];
    assign full      = (COUNT == CW'(DEPTH));
    assign rd        = OUT_VALID & OUT_READY;
    // A same-cycle read frees the slot, so a full FIFO can still accept.
    assign wr_acc    = wr & (~full | rd);

    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            COUNT    <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (wr_acc) begin
                mem[wr_ptr] <= aligned;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_acc, rd})
                2'b10:   COUNT <= COUNT + CW'(1);
                2'b01:   COUNT <= COUNT - CW'(1);
                default: COUNT <= COUNT;
            endcase
            if (wr & ~wr_acc) OVERFLOW <= 1'b1;
        end
    end

endmodule

// File: tb/tb_systolic_output_deskew.sv
// Directed and random stimulus for systolic_output_deskew, checked against a queue-based row model.
module tb_systolic_output_deskew;
    localparam int WIDTH  = 8;
    localparam int LENGTH = 4;
    localparam int DEPTH  = 4;
    localparam int PW     = 2*WIDTH + 1;
    localparam int DW     = PW*LENGTH;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          SYNC_RST = 1'b0;
    logic          EN = 1'b0;
    logic          IN_VALID = 1'b0;
    logic [DW-1:0] PSUM_IN = '0;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;
    logic [DW-1:0] OUT_DATA;
    logic [CW-1:0] COUNT;
    logic          OVERFLOW;

    always #5 CLK = ~CLK;

    systolic_output_deskew #(.WIDTH(WIDTH), .LENGTH(LENGTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .SYNC_RST(SYNC_RST), .EN(EN), .IN_VALID(IN_VALID), .PSUM_IN(PSUM_IN),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .COUNT(COUNT), .OVERFLOW(OVERFLOW)
    );

    int checks = 0;
    int errors = 0;

    // Reference: history of enabled-cycle inputs plus a row queue.
    logic [DW-1:0] hist [$];
    logic          vh   [$];
    logic [DW-1:0] fq   [$];
    logic          m_ovf = 1'b0;

    int            tcyc;
    int            first_vld;
    int            nvld;
    logic [DW-1:0] seen [$];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] col_of(input logic [DW-1:0] v, input int c);
        return v[DW-1-c*PW -: PW];
    endfunction

    function automatic logic [DW-1:0] row_val(input int base, input int r);
        logic [DW-1:0] v = '0;
        for (int c = 0; c < LENGTH; c++) v[DW-1-c*PW -: PW] = PW'(base + 16*r + c);
        return v;
    endfunction

    function automatic logic [DW-1:0] rnd_vec();
        logic [DW-1:0] v = '0;
        for (int c = 0; c < LENGTH; c++) v[DW-1-c*PW -: PW] = PW'($urandom);
        return v;
    endfunction

    // Input vector for enabled step n of a burst: column c carries row n-c.
    function automatic logic [DW-1:0] skew_vec(input int n, input int n_rows, input int base);
        logic [DW-1:0] v = rnd_vec();
        for (int c = 0; c < LENGTH; c++)
            if (n - c >= 0 && n - c < n_rows) v[DW-1-c*PW -: PW] = PW'(base + 16*(n-c) + c);
        return v;
    endfunction

    task automatic model_update();
        logic          wr = 1'b0;
        logic          rd;
        logic          full;
        logic [DW-1:0] row = '0;
        if (SYNC_RST) begin
            hist.delete(); vh.delete(); fq.delete();
            m_ovf = 1'b0;
        end else begin
            if (EN) begin
                hist.push_back(PSUM_IN);
                vh.push_back(IN_VALID);
                if (vh.size() == LENGTH) begin
                    if (vh[0]) begin
                        wr = 1'b1;
                        for (int c = 0; c < LENGTH; c++) row[DW-1-c*PW -: PW] = col_of(hist[c], c);
                    end
                    void'(hist.pop_front());
                    void'(vh.pop_front());
                end
            end
            rd   = (fq.size() > 0) && OUT_READY;
            full = (fq.size() == DEPTH);
            if (rd) void'(fq.pop_front());
            if (wr) begin
                if (!full || rd) fq.push_back(row);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic compare();
        chk("out_valid", DW'(OUT_VALID), DW'(fq.size() != 0));
        chk("count", DW'(COUNT), DW'(fq.size()));
        chk("overflow", DW'(OVERFLOW), DW'(m_ovf));
        if (fq.size() > 0) chk("out_data", OUT_DATA, fq[0]);
    endtask

    task automatic step(input logic en, input logic iv, input logic [DW-1:0] ps,
                        input logic rdy, input logic rst);
        EN = en; IN_VALID = iv; PSUM_IN = ps; OUT_READY = rdy; SYNC_RST = rst;
        if (OUT_VALID === 1'b1) begin
            if (first_vld < 0) first_vld = tcyc;
            nvld++;
            if (rdy) seen.push_back(OUT_DATA);
        end
        @(posedge CLK);
        model_update();
        #1;
        compare();
        tcyc++;
    endtask

    task automatic begin_test();
        tcyc = 0; first_vld = -1; nvld = 0;
        seen.delete();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, rnd_vec(), 1'b0, 1'b1);
        begin_test();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, rnd_vec(), rdy, 1'b0);
    endtask

    task automatic drive_rows(input int n_rows, input int base, input logic rdy,
                              input int rdy_n, input int stall_at, input int stall_len);
        int n = 0;
        int t = 0;
        logic e;
        logic r;
        while (n < n_rows + LENGTH - 1) begin
            e = !(t >= stall_at && t < stall_at + stall_len);
            r = (rdy_n >= 0) ? (e && n == rdy_n) : rdy;
            step(e, (n < n_rows), skew_vec(n, n_rows, base), r, 1'b0);
            if (e) n++;
            t++;
        end
    endtask

    initial begin
        begin_test();
        // Reset state
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("rst_valid", DW'(OUT_VALID), '0);
        chk("rst_count", DW'(COUNT), '0);
        chk("rst_ovf", DW'(OVERFLOW), '0);
        chk("rst_data", OUT_DATA, '0);

        // Single row
        do_reset();
        drive_rows(1, 1, 1'b1, -1, 1000, 0);
        idle(4, 1'b1);
        chk("single_first", DW'(first_vld), DW'(4));
        chk("single_nvld", DW'(nvld), DW'(1));
        chk("single_data", seen.size() > 0 ? seen[0] : '0, row_val(1, 0));
        chk("single_count", DW'(COUNT), '0);

        // Streaming 8 rows
        do_reset();
        drive_rows(8, 0, 1'b1, -1, 1000, 0);
        idle(4, 1'b1);
        chk("stream_first", DW'(first_vld), DW'(4));
        chk("stream_nvld", DW'(nvld), DW'(8));
        chk("stream_ovf", DW'(OVERFLOW), '0);
        for (int r = 0; r < 8; r++) chk("stream_row", seen.size() > r ? seen[r] : '0, row_val(0, r));

        // Backpressure and overflow
        do_reset();
        drive_rows(5, 0, 1'b0, -1, 1000, 0);
        chk("bp_count", DW'(COUNT), DW'(4));
        chk("bp_ovf", DW'(OVERFLOW), DW'(1));
        idle(6, 1'b1);
        chk("bp_nrows", DW'(seen.size()), DW'(4));
        for (int r = 0; r < 4; r++) chk("bp_row", seen.size() > r ? seen[r] : '0, row_val(0, r));

        // Full with simultaneous read
        do_reset();
        drive_rows(4, 0, 1'b0, -1, 1000, 0);
        chk("fr_full", DW'(COUNT), DW'(4));
        drive_rows(1, 256, 1'b0, 3, 1000, 0);
        chk("fr_count", DW'(COUNT), DW'(4));
        chk("fr_ovf", DW'(OVERFLOW), '0);
        idle(6, 1'b1);
        chk("fr_nrows", DW'(seen.size()), DW'(5));
        for (int r = 1; r < 4; r++) chk("fr_row", seen.size() > r ? seen[r] : '0, row_val(0, r));
        chk("fr_last", seen.size() > 4 ? seen[4] : '0, row_val(256, 0));

        // EN stall inside the window
        do_reset();
        drive_rows(1, 1, 1'b1, -1, 2, 2);
        idle(4, 1'b1);
        chk("stall_first", DW'(first_vld), DW'(6));
        chk("stall_nvld", DW'(nvld), DW'(1));
        chk("stall_data", seen.size() > 0 ? seen[0] : '0, row_val(1, 0));

        // Reset with a row in flight and two rows queued
        do_reset();
        drive_rows(2, 0, 1'b0, -1, 1000, 0);
        chk("mr_count2", DW'(COUNT), DW'(2));
        step(1'b1, 1'b1, skew_vec(0, 1, 1), 1'b0, 1'b0);
        step(1'b1, 1'b0, skew_vec(1, 1, 1), 1'b0, 1'b0);
        step(1'b1, 1'b0, skew_vec(2, 1, 1), 1'b0, 1'b1);
        chk("mr_valid", DW'(OUT_VALID), '0);
        chk("mr_count", DW'(COUNT), '0);
        chk("mr_ovf", DW'(OVERFLOW), '0);
        begin_test();
        step(1'b1, 1'b0, skew_vec(3, 1, 1), 1'b1, 1'b0);
        idle(8, 1'b1);
        chk("mr_nvld", DW'(nvld), '0);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            int rdy_pct;
            rdy_pct = (i / 250) % 2 == 0 ? 80 : 25;
            step(($urandom % 6) != 0, ($urandom % 3) == 0, rnd_vec(),
                 ($urandom % 100) < rdy_pct, ($urandom % 200) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
